// File: rtl/interface_axis_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interface_axis_master_pkg
// Purpose  : Shared state encoding and data-width constants for the buffer
//            to AXI4-Stream master.
// Revision : 1.0 - initial release
// ============================================================================
package interface_axis_master_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int BRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/interface_axis_master_if.sv
`default_nettype none
// ============================================================================
// Module   : interface_axis_master_if
// Purpose  : AXI4-Stream bundle (tdata/tvalid/tlast/tready) with master and
//            slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface interface_axis_master_if;
  import interface_axis_master_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_fifo2
// Purpose  : Two-entry output FIFO. The head entry is a plain register so the
//            stream outputs never depend combinationally on the pop request.
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_fifo2
  import interface_axis_master_pkg::*;
#(
  parameter int WIDTH = AXIS_DATA_W + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_din,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_dout,
  output logic                  o_valid,
  output logic      [1:0]       o_occ
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;

  // Head/tail storage and occupancy; pop is only ever requested when valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= i_din;
          else               r_tail <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (r_occ == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout  = r_head;
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/interface_axis_master.sv
`default_nettype none
// ============================================================================
// Module   : interface_axis_master
// Purpose  : Streams base..base+len of a 64-bit buffer memory out as an
//            AXI4-Stream master, tolerating the one-cycle read latency and
//            sink backpressure through a 2-entry output FIFO.
// Options  : INTERFACE_AXIS_MASTER_STALL_CNT_EN adds the stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module interface_axis_master
  import interface_axis_master_pkg::*;
#(
  parameter int ADDR_BIT = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   send_enable,
  input  wire logic [ADDR_BIT-1:0]    send_len,
  input  wire logic [ADDR_BIT-1:0]    send_base,
  output logic                        send_done,
  output logic                        busy,
  output logic      [ADDR_BIT-1:0]    read_addr,
  output logic                        read_enable,
  input  wire logic [AXIS_DATA_W-1:0] read_data,
`ifdef INTERFACE_AXIS_MASTER_STALL_CNT_EN
  output logic      [31:0]            stall_cycles,
`endif
  interface_axis_master_if.master     m_axis
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_BIT-1:0] r_len;
  logic [ADDR_BIT-1:0] r_issue_cnt;
  logic [ADDR_BIT-1:0] r_read_addr;
  logic                r_inflight;
  logic                r_inflight_last;

  logic                   w_start;
  logic                   w_is_last;
  logic                   w_rd_en;
  logic                   w_pop;
  logic                   w_valid;
  logic [1:0]             w_occ;
  logic [AXIS_DATA_W:0]   w_head;
  logic [2:0]             w_need;
  logic [2:0]             w_cap;

  assign w_start   = (r_state == IDLE) && send_enable;
  assign w_is_last = (r_issue_cnt == r_len);
  assign w_pop     = w_valid && m_axis.tready;

  // Entries held or on their way must fit in the FIFO after this cycle's pop.
  assign w_need  = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_cap   = 3'd2 + {2'b00, w_pop};
  assign w_rd_en = (r_state == ISSUE) && (w_need < w_cap);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; the tlast handshake closes the transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (send_enable)           w_next = ISSUE;
      ISSUE:   if (w_rd_en && w_is_last)  w_next = DRAIN;
      DRAIN:   if (w_pop && w_head[AXIS_DATA_W]) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Transfer parameters, issue counter and the registered read address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_read_addr <= '0;
    end else if (w_start) begin
      r_len       <= send_len;
      r_issue_cnt <= '0;
      r_read_addr <= send_base;
    end else if (w_rd_en) begin
      r_issue_cnt <= r_issue_cnt + 1'b1;
      r_read_addr <= r_read_addr + 1'b1;
    end
  end

  // Read-latency stage: remembers a read is returning and whether it is last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && w_is_last;
    end
  end

  axis_skid_fifo2 #(
    .WIDTH (AXIS_DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_din   ({r_inflight_last, read_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_valid (w_valid),
    .o_occ   (w_occ)
  );

  assign m_axis.tdata  = w_head[AXIS_DATA_W-1:0];
  assign m_axis.tlast  = w_head[AXIS_DATA_W];
  assign m_axis.tvalid = w_valid;

  assign read_addr   = r_read_addr;
  assign read_enable = w_rd_en;
  assign busy        = (r_state != IDLE);
  assign send_done   = (r_state == FINISH);

`ifdef INTERFACE_AXIS_MASTER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts sink stalls of the current transfer, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_stall_cnt <= 32'd0;
    else if (w_start)                        r_stall_cnt <= 32'd0;
    else if (w_valid && !m_axis.tready && (r_stall_cnt != 32'hFFFF_FFFF))
                                             r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_interface_axis_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_interface_axis_master
// Purpose  : Directed self-checking bench for interface_axis_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interface_axis_master;

  logic        clk;
  logic        rst;
  logic        send_enable;
  logic [15:0] send_len;
  logic [15:0] send_base;
  logic        send_done;
  logic        busy;
  logic [15:0] read_addr;
  logic        read_enable;
  logic [63:0] read_data;
`ifdef INTERFACE_AXIS_MASTER_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_vec;
  int n_err;

  interface_axis_master_if axis ();

  interface_axis_master #(.ADDR_BIT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .send_enable  (send_enable),
    .send_len     (send_len),
    .send_base    (send_base),
    .send_done    (send_done),
    .busy         (busy),
    .read_addr    (read_addr),
    .read_enable  (read_enable),
    .read_data    (read_data),
`ifdef INTERFACE_AXIS_MASTER_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .m_axis       (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer memory contents are a fixed function of the address.
  function automatic logic [63:0] mem_val(input logic [15:0] a);
    return {16'hDA7A, a, ~a, 16'h5A5A ^ a};
  endfunction

  // One-cycle-latency buffer memory.
  always @(posedge clk) begin
    if (read_enable) read_data <= mem_val(read_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] base, input logic [15:0] len);
    @(negedge clk);
    send_base   = base;
    send_len    = len;
    send_enable = 1'b1;
    @(negedge clk);
    send_enable = 1'b0;
  endtask

  // mode: 0 tready high, 1 random tready, 2 tready low on cycles 4..8.
  // abort_beats: nonzero -> assert rst once that many beats have been taken.
  // poke_cyc: cycle index at which a stray send_enable is pulsed.
  task automatic run_xfer(input logic [15:0] base, input logic [15:0] len,
                          input int mode, input int abort_beats, input int poke_cyc);
    int          cyc, beats, nrd, first_v, last_hs, done_cnt, done_cyc;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [15:0] exp_addr;
    logic [15:0] beat_idx;
    bit          fin;
    bit          aborted;

    start(base, len);
    cyc = 1; beats = 0; nrd = 0; first_v = -1; last_hs = -1;
    done_cnt = 0; done_cyc = -1; prev_stall = 1'b0; prev_data = '0;
    prev_last = 1'b0; fin = 1'b0; aborted = 1'b0;

    while (!fin) begin
      case (mode)
        1:       axis.tready = 1'($urandom_range(0, 1));
        2:       axis.tready = !((cyc >= 4) && (cyc <= 8));
        default: axis.tready = 1'b1;
      endcase
      send_enable = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        send_base = 16'h7777;
        send_len  = 16'd5;
      end
      #1;
      if (prev_stall) begin
        check("hold_tvalid", 64'(axis.tvalid), 64'd1);
        check("hold_tdata",  axis.tdata, prev_data);
        check("hold_tlast",  64'(axis.tlast), 64'(prev_last));
      end
      if (axis.tvalid && (first_v < 0)) first_v = cyc;
      if (read_enable) begin
        exp_addr = base + nrd[15:0];
        check("read_addr", 64'(read_addr), 64'(exp_addr));
        nrd++;
      end
      if (axis.tvalid && axis.tready) begin
        beat_idx = beats[15:0];
        exp_addr = base + beat_idx;
        check("tdata", axis.tdata, mem_val(exp_addr));
        check("tlast", 64'(axis.tlast), 64'(beat_idx == len));
        beats++;
        last_hs = cyc;
      end
      if (send_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;

      if ((abort_beats != 0) && (beats == abort_beats)) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_tvalid",  64'(axis.tvalid), 64'd0);
        check("rst_tlast",   64'(axis.tlast), 64'd0);
        check("rst_tdata",   axis.tdata, 64'd0);
        check("rst_rd_en",   64'(read_enable), 64'd0);
        check("rst_rd_addr", 64'(read_addr), 64'd0);
        check("rst_done",    64'(send_done), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          #1;
          check("abort_no_done", 64'(send_done), 64'd0);
          check("abort_idle",    64'(busy), 64'd0);
          @(negedge clk);
        end
        fin = 1'b1;
        aborted = 1'b1;
      end else if ((done_cnt != 0) || (cyc >= 400)) begin
        fin = 1'b1;
      end
      if (!aborted) begin
        @(negedge clk);
        cyc++;
      end
    end
    send_enable = 1'b0;

    if (!aborted) begin
      check("done_count",  64'(done_cnt), 64'd1);
      check("done_delay",  64'(done_cyc), 64'(last_hs + 1));
      check("beat_count",  64'(beats), 64'(int'(len) + 1));
      check("read_count",  64'(nrd), 64'(int'(len) + 1));
      check("first_valid", 64'(first_v), 64'd3);
      if (mode == 0) check("throughput", 64'(last_hs - first_v), 64'(int'(len)));
      for (int i = 0; i < 3; i++) begin
        #1;
        check("post_done", 64'(send_done), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_rd_en", 64'(read_enable), 64'd0);
`ifdef INTERFACE_AXIS_MASTER_STALL_CNT_EN
        if (mode == 2)      check("stall_cnt", 64'(stall_cycles), 64'd5);
        else if (mode == 0) check("stall_cnt", 64'(stall_cycles), 64'd0);
`endif
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    send_enable = 1'b0;
    send_len    = '0;
    send_base   = '0;
    axis.tready = 1'b0;
    read_data   = '0;
    #17;
    check("reset_tvalid",  64'(axis.tvalid), 64'd0);
    check("reset_tlast",   64'(axis.tlast), 64'd0);
    check("reset_tdata",   axis.tdata, 64'd0);
    check("reset_rd_en",   64'(read_enable), 64'd0);
    check("reset_rd_addr", 64'(read_addr), 64'd0);
    check("reset_done",    64'(send_done), 64'd0);
    check("reset_busy",    64'(busy), 64'd0);
`ifdef INTERFACE_AXIS_MASTER_STALL_CNT_EN
    check("reset_stall",   64'(stall_cycles), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_xfer(16'h0010, 16'd0,  0, 0, 0);  // single beat
    run_xfer(16'h0000, 16'd7,  0, 0, 0);  // back-to-back burst
    run_xfer(16'h0100, 16'd15, 1, 0, 0);  // random backpressure
    run_xfer(16'hFFFE, 16'd3,  0, 0, 0);  // address wrap
    run_xfer(16'h0200, 16'd9,  0, 3, 0);  // reset mid-transfer
    run_xfer(16'h0300, 16'd9,  0, 0, 0);  // clean transfer after abort
    run_xfer(16'h0400, 16'd7,  0, 0, 9);  // stray start during DRAIN
    run_xfer(16'h0500, 16'd3,  2, 0, 0);  // five stall cycles
    run_xfer(16'h0600, 16'd1,  0, 0, 0);  // stall counter cleared on start

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
